// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Inter-stage register for the pipelined MIPS core. One instance sits on each
// stage boundary (F/D, D/E, E/M, M/W) and carries the instruction, its PC,
// a valid bit, a merged exception code and the branch-delay flag. The stage
// can be held (stall), squashed to a bubble (flush) or redirected to the
// exception handler (exc_flush). Two saturating counters record how many
// cycles the stage was stalled and how many bubbles it inserted.
//
// Ports:
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-low reset
//   stall      in   1        hold all stage state this cycle
//   flush      in   1        load a bubble
//   exc_flush  in   1        exception/eret flush, highest non-reset priority
//   valid_in   in   1        upstream slot holds a real instruction
//   instr_in   in   INSTR_W  upstream instruction
//   pc_in      in   PC_W     upstream PC
//   bd_in      in   1        upstream instruction is in a branch delay slot
//   exc_in     in   EXC_W    exception code from upstream (0 = none)
//   exc_local  in   EXC_W    exception detected at this boundary
//   cnt_clr    in   1        synchronous clear of both counters
//   valid_out  out  1        registered valid
//   instr_out  out  INSTR_W  registered instruction
//   pc_out     out  PC_W     registered PC
//   bd_out     out  1        registered branch-delay flag
//   exc_out    out  EXC_W    registered merged exception code
//   stall_cnt  out  CNT_W    cycles spent stalled (saturating)
//   bubble_cnt out  CNT_W    bubbles inserted (saturating)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int              INSTR_W    = 32,
  parameter int              PC_W       = 32,
  parameter int              EXC_W      = 5,
  parameter int              CNT_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [PC_W-1:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               exc_flush,
  input  logic               valid_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               bd_in,
  input  logic [EXC_W-1:0]   exc_in,
  input  logic [EXC_W-1:0]   exc_local,
  input  logic               cnt_clr,
  output logic               valid_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               bd_out,
  output logic [EXC_W-1:0]   exc_out,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic               r_bd;
  logic [EXC_W-1:0]   r_exc;
  logic [CNT_W-1:0]   r_stallCnt;
  logic [CNT_W-1:0]   r_bubbleCnt;

  logic               w_stallEvent;
  logic               w_bubbleEvent;
  logic [EXC_W-1:0]   w_excMerged;
  logic [INSTR_W-1:0] w_instrLoad;

  // Events that feed the performance counters. An exception flush swallows
  // both, and a stall masks a concurrent flush so no bubble is counted.
  always_comb begin
    w_stallEvent  = 1'b0;
    w_bubbleEvent = 1'b0;
    if (!exc_flush) begin
      w_stallEvent  = stall;
      w_bubbleEvent = flush && !stall;
    end
  end

  // An empty slot carries neither an instruction nor an exception; for a
  // real instruction the older (upstream) exception takes precedence over
  // one raised at this boundary.
  always_comb begin
    w_excMerged = '0;
    w_instrLoad = '0;
    if (valid_in) begin
      w_instrLoad = instr_in;
      w_excMerged = (exc_in != '0) ? exc_in : exc_local;
    end
  end

  // Stage payload. Priority: reset, exception flush, stall (hold), bubble
  // flush, normal load. A bubble keeps pc/bd so CP0 still sees the correct
  // architectural PC and delay-slot flag for the squashed slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= RESET_PC;
      r_bd    <= 1'b0;
      r_exc   <= '0;
    end else if (exc_flush) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= HANDLER_PC;
      r_bd    <= 1'b0;
      r_exc   <= '0;
    end else if (stall) begin
      r_valid <= r_valid;
      r_instr <= r_instr;
      r_pc    <= r_pc;
      r_bd    <= r_bd;
      r_exc   <= r_exc;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= pc_in;
      r_bd    <= bd_in;
      r_exc   <= '0;
    end else begin
      r_valid <= valid_in;
      r_instr <= w_instrLoad;
      r_pc    <= pc_in;
      r_bd    <= bd_in;
      r_exc   <= w_excMerged;
    end
  end

  // Saturating performance counters. A clear beats a same-cycle increment,
  // and a counter that reached all-ones simply stays there.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stallCnt  <= '0;
      r_bubbleCnt <= '0;
    end else if (cnt_clr) begin
      r_stallCnt  <= '0;
      r_bubbleCnt <= '0;
    end else begin
      if (w_stallEvent && (r_stallCnt != '1)) begin
        r_stallCnt <= r_stallCnt + 1'b1;
      end
      if (w_bubbleEvent && (r_bubbleCnt != '1)) begin
        r_bubbleCnt <= r_bubbleCnt + 1'b1;
      end
    end
  end

  assign valid_out  = r_valid;
  assign instr_out  = r_instr;
  assign pc_out     = r_pc;
  assign bd_out     = r_bd;
  assign exc_out    = r_exc;
  assign stall_cnt  = r_stallCnt;
  assign bubble_cnt = r_bubbleCnt;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage register for the pipelined MIPS core; one instance per stage boundary (F/D, D/E, E/M, M/W).
- Carries instruction, PC, a valid bit, an exception code and a branch-delay flag.
- Supports stall (hold), bubble flush, and exception flush to the handler PC.
- Keeps saturating stall and bubble counters for performance debug.

Parameters:
- INSTR_W, 32, instruction field width
- PC_W, 32, PC field width
- EXC_W, 5, exception code width; 0 means no exception
- CNT_W, 16, width of each performance counter
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- HANDLER_PC, 32'h0000_4180, PC value loaded on exception flush

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- stall  in  1  hold all stage state this cycle
- flush  in  1  load a bubble (branch/hazard squash)
- exc_flush  in  1  exception/eret flush from CP0; highest non-reset priority
- valid_in  in  1  upstream slot holds a real instruction
- instr_in  in  INSTR_W  upstream instruction
- pc_in  in  PC_W  upstream PC
- bd_in  in  1  upstream instruction is in a branch delay slot
- exc_in  in  EXC_W  exception code carried from upstream
- exc_local  in  EXC_W  exception detected at this boundary
- cnt_clr  in  1  synchronous clear of both counters
- valid_out  out  1  registered valid
- instr_out  out  INSTR_W  registered instruction
- pc_out  out  PC_W  registered PC
- bd_out  out  1  registered branch-delay flag
- exc_out  out  EXC_W  registered merged exception code
- stall_cnt  out  CNT_W  cycles spent stalled
- bubble_cnt  out  CNT_W  bubbles inserted

Behaviour:
- All outputs are registered. Update priority, highest first: reset, exc_flush, stall, flush, load.
- Reset (reset==0):
  - valid_out=0, instr_out=0, pc_out=RESET_PC, bd_out=0, exc_out=0.
  - stall_cnt=0, bubble_cnt=0.
  - All other inputs are ignored that cycle.
- exc_flush=1:
  - valid_out=0, instr_out=0, bd_out=0, exc_out=0, pc_out=HANDLER_PC.
  - Overrides stall and flush.
  - Neither counter increments.
- stall=1 (exc_flush=0):
  - All data fields hold their values.
  - stall_cnt increments.
  - A concurrent flush is ignored: no bubble, and bubble_cnt does not increment.
- flush=1 (stall=0, exc_flush=0): bubble load.
  - valid_out=0, instr_out=0, exc_out=0.
  - pc_out=pc_in and bd_out=bd_in, so the bubble keeps a correct macroscopic PC and BD flag for CP0.
  - bubble_cnt increments.
- Load (no control asserted):
  - valid_out=valid_in, instr_out=instr_in, pc_out=pc_in, bd_out=bd_in.
  - exc_out=(exc_in!=0) ? exc_in : exc_local. The upstream exception wins.
  - If valid_in=0, exc_out=0 and instr_out=0 regardless of the other inputs.
- Latency: exactly 1 cycle from input to output on load; 0 cycles of added delay otherwise.
- Counters:
  - Both saturate at 2^CNT_W-1 and never wrap.
  - cnt_clr=1 forces both to 0 on the next edge and beats a same-cycle increment.
  - Reset also clears both.
- Reset mid-stall or mid-flush: reset wins and loads the reset values above. Counting resumes from 0 after reset is released.
- There are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then load with valid_in=1, instr_in=0x8C010004, pc_in=0x3004, exc_in=0, exc_local=0 → next cycle: valid_out=1, instr_out=0x8C010004, pc_out=0x3004, exc_out=0; during reset pc_out=0x3000.
- Load, then stall=1 for 3 cycles while inputs change → outputs hold the first load; stall_cnt=3. Then stall=1 with flush=1 for 1 cycle → outputs still held, stall_cnt=4, bubble_cnt=0.
- flush=1 with pc_in=0x3010, bd_in=1, instr_in=0x1234 → valid_out=0, instr_out=0, pc_out=0x3010, bd_out=1, bubble_cnt=1.
- Exception merge:
  - exc_in=4, exc_local=10 → exc_out=4.
  - exc_in=0, exc_local=10 → exc_out=10.
  - valid_in=0, exc_local=10 → exc_out=0.
- exc_flush=1 together with stall=1 and flush=1 → pc_out=0x4180, valid_out=0, instr_out=0; no counter changes.
- With CNT_W=2: stall for 5 cycles → stall_cnt stays at 3. Then cnt_clr=1 with stall=1 → stall_cnt=0. Then reset=0 during a stall → all outputs at their reset values.
